// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles both requester ports and the data-memory side of the
//               data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if;
    // Port 0: pipeline memory-access stage
    logic        p0_req;
    logic        p0_wEn;
    logic [1:0]  p0_size;
    logic        p0_sign;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;

    // Port 1: loader / debug master
    logic        p1_req;
    logic        p1_wEn;
    logic [1:0]  p1_size;
    logic        p1_sign;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_lock;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;

    // Data memory side
    logic        mem_wEn;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p0_wEn, p0_size, p0_sign, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        input  p1_req, p1_wEn, p1_size, p1_sign, p1_addr, p1_wdata, p1_lock,
        output p1_gnt, p1_rvalid, p1_rdata,
        output mem_wEn, mem_size, mem_sign, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_wEn, p0_size, p0_sign, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        output p1_req, p1_wEn, p1_size, p1_sign, p1_addr, p1_wdata, p1_lock,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  mem_wEn, mem_size, mem_sign, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter for the single-port data memory with bounded
//               port-1 starvation and a port-1 lock for exclusive bursts.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam int                c_CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_WAIT);

    localparam logic [0:0] c_OPEN   = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

    logic [0:0]         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_p0_rvalid;
    logic               r_p1_rvalid;
    logic [31:0]        r_p0_rdata;
    logic [31:0]        r_p1_rdata;

    logic               w_p0_gnt;
    logic               w_p1_gnt;

    // Grants are forced low during reset so no memory write can leak out.
    always_comb begin
        w_p0_gnt = 1'b0;
        w_p1_gnt = 1'b0;
        if (!rst) begin
            if (r_state == c_LOCKED) begin
                w_p1_gnt = bus.p1_req;
            end else begin
                w_p0_gnt = bus.p0_req && (r_wait_cnt < c_MAX_CNT);
                w_p1_gnt = bus.p1_req && !w_p0_gnt;
            end
        end
    end

    always_comb begin
        bus.mem_wEn   = 1'b0;
        bus.mem_size  = 2'b00;
        bus.mem_sign  = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        if (w_p0_gnt) begin
            bus.mem_wEn   = bus.p0_wEn;
            bus.mem_size  = bus.p0_size;
            bus.mem_sign  = bus.p0_sign;
            bus.mem_addr  = bus.p0_addr;
            bus.mem_wdata = bus.p0_wdata;
        end else if (w_p1_gnt) begin
            bus.mem_wEn   = bus.p1_wEn;
            bus.mem_size  = bus.p1_size;
            bus.mem_sign  = bus.p1_sign;
            bus.mem_addr  = bus.p1_addr;
            bus.mem_wdata = bus.p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_OPEN;
            r_wait_cnt  <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_p0_rdata  <= 32'h0;
            r_p1_rdata  <= 32'h0;
        end else begin
            r_p0_rvalid <= w_p0_gnt && !bus.p0_wEn;
            r_p1_rvalid <= w_p1_gnt && !bus.p1_wEn;
            if (w_p0_gnt && !bus.p0_wEn) begin
                r_p0_rdata <= bus.mem_rdata;
            end
            if (w_p1_gnt && !bus.p1_wEn) begin
                r_p1_rdata <= bus.mem_rdata;
            end

            case (r_state)
                c_OPEN: begin
                    if (w_p1_gnt && bus.p1_lock) begin
                        r_state <= c_LOCKED;
                    end
                end
                default: begin
                    if (!bus.p1_lock) begin
                        r_state <= c_OPEN;
                    end
                end
            endcase

            // Starvation counter only matters while port 0 can compete.
            if ((r_state == c_LOCKED) || w_p1_gnt || !bus.p1_req) begin
                r_wait_cnt <= '0;
            end else if (r_wait_cnt != c_MAX_CNT) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
        end
    end

    assign bus.p0_gnt    = w_p0_gnt;
    assign bus.p1_gnt    = w_p1_gnt;
    assign bus.p0_rvalid = r_p0_rvalid;
    assign bus.p1_rvalid = r_p1_rvalid;
    assign bus.p0_rdata  = r_p0_rdata;
    assign bus.p1_rdata  = r_p1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               word-addressed memory model behind it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [31:0] tb_mem [0:63];

    dmem_arbiter_if bus ();

    dmem_arbiter #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous write, combinational read
    always @(posedge clk) begin
        if (bus.mem_wEn) tb_mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = tb_mem[bus.mem_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic wen, input logic [31:0] addr, input logic [31:0] wdata);
        bus.p0_req   = req;
        bus.p0_wEn   = wen;
        bus.p0_addr  = addr;
        bus.p0_wdata = wdata;
    endtask

    task automatic set_p1(input logic req, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic lock);
        bus.p1_req   = req;
        bus.p1_wEn   = wen;
        bus.p1_addr  = addr;
        bus.p1_wdata = wdata;
        bus.p1_lock  = lock;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.p0_size = 2'b10;
        bus.p0_sign = 1'b0;
        bus.p1_size = 2'b10;
        bus.p1_sign = 1'b0;
        set_p0(1'b1, 1'b1, 32'h40, 32'h11111111);
        set_p1(1'b1, 1'b1, 32'h44, 32'h22222222, 1'b1);

        // Reset cycle with both requesting stores
        next_cycle();
        @(negedge clk);
        check("rst_p0_gnt",    32'(bus.p0_gnt),    32'h0);
        check("rst_p1_gnt",    32'(bus.p1_gnt),    32'h0);
        check("rst_mem_wEn",   32'(bus.mem_wEn),   32'h0);
        check("rst_mem_addr",  bus.mem_addr,       32'h0);
        check("rst_mem_wdata", bus.mem_wdata,      32'h0);
        check("rst_p0_rdata",  bus.p0_rdata,       32'h0);
        check("rst_p1_rdata",  bus.p1_rdata,       32'h0);
        check("rst_p0_rvalid", 32'(bus.p0_rvalid), 32'h0);
        check("rst_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);

        // p0 store then load of 0x40
        next_cycle();
        rst = 1'b0;
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_p0(1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        @(negedge clk);
        check("st_p0_gnt",    32'(bus.p0_gnt),  32'h1);
        check("st_mem_wEn",   32'(bus.mem_wEn), 32'h1);
        check("st_mem_addr",  bus.mem_addr,     32'h40);
        check("st_mem_wdata", bus.mem_wdata,    32'hDEADBEEF);
        check("st_mem_size",  32'(bus.mem_size), 32'h2);

        next_cycle();
        set_p0(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("ld_p0_gnt",      32'(bus.p0_gnt),    32'h1);
        check("ld_mem_wEn",     32'(bus.mem_wEn),   32'h0);
        check("ld_no_st_rvalid", 32'(bus.p0_rvalid), 32'h0);

        next_cycle();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("ld_p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
        check("ld_p0_rdata",  bus.p0_rdata,       32'hDEADBEEF);
        check("ld_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);

        // Both loading continuously: four p0 grants, then one p1 grant
        for (int i = 0; i < 9; i++) begin
            next_cycle();
            set_p0(1'b1, 1'b0, 32'h40, 32'h0);
            set_p1(1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
            @(negedge clk);
            check($sformatf("rr_p0_gnt_%0d", i), 32'(bus.p0_gnt), (i % 5 < 4) ? 32'h1 : 32'h0);
            check($sformatf("rr_p1_gnt_%0d", i), 32'(bus.p1_gnt), (i % 5 == 4) ? 32'h1 : 32'h0);
            check($sformatf("rr_p1_rvalid_%0d", i), 32'(bus.p1_rvalid), (i == 5) ? 32'h1 : 32'h0);
        end

        // Counter saturated: p1 wins and locks
        next_cycle();
        bus.p1_lock = 1'b1;
        @(negedge clk);
        check("lk0_p0_gnt",   32'(bus.p0_gnt), 32'h0);
        check("lk0_p1_gnt",   32'(bus.p1_gnt), 32'h1);
        check("lk0_mem_addr", bus.mem_addr,    32'h44);
        for (int i = 1; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("lk%0d_p0_gnt", i), 32'(bus.p0_gnt), 32'h0);
            check($sformatf("lk%0d_p1_gnt", i), 32'(bus.p1_gnt), 32'h1);
        end
        next_cycle();
        bus.p1_lock = 1'b0;
        @(negedge clk);
        check("rel_p0_gnt", 32'(bus.p0_gnt), 32'h0);
        check("rel_p1_gnt", 32'(bus.p1_gnt), 32'h1);
        next_cycle();
        @(negedge clk);
        check("open_p0_gnt", 32'(bus.p0_gnt), 32'h1);
        check("open_p1_gnt", 32'(bus.p1_gnt), 32'h0);

        // p0 load, then p1 store overlapping p0's rvalid
        next_cycle();
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_p0(1'b1, 1'b0, 32'h40, 32'h0);
        @(negedge clk);
        check("ov_p0_gnt", 32'(bus.p0_gnt), 32'h1);
        next_cycle();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        set_p1(1'b1, 1'b1, 32'h48, 32'h12345678, 1'b0);
        @(negedge clk);
        check("ov_p0_rvalid",  32'(bus.p0_rvalid), 32'h1);
        check("ov_p0_rdata",   bus.p0_rdata,       32'hDEADBEEF);
        check("ov_p1_gnt",     32'(bus.p1_gnt),    32'h1);
        check("ov_mem_wEn",    32'(bus.mem_wEn),   32'h1);
        check("ov_mem_addr",   bus.mem_addr,       32'h48);
        check("ov_mem_wdata",  bus.mem_wdata,      32'h12345678);
        next_cycle();
        set_p1(1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
        @(negedge clk);
        check("p1ld_gnt",       32'(bus.p1_gnt),    32'h1);
        check("p1ld_no_rvalid", 32'(bus.p1_rvalid), 32'h0);
        next_cycle();
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("p1ld_rvalid",   32'(bus.p1_rvalid), 32'h1);
        check("p1ld_rdata",    bus.p1_rdata,       32'h12345678);
        check("idle_mem_addr", bus.mem_addr,       32'h0);
        check("idle_mem_wEn",  32'(bus.mem_wEn),   32'h0);

        // Reset in the middle of a locked burst
        next_cycle();
        set_p1(1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
        @(negedge clk);
        check("br_p1_gnt", 32'(bus.p1_gnt), 32'h1);
        next_cycle();
        rst = 1'b1;
        set_p0(1'b1, 1'b0, 32'h40, 32'h0);
        set_p1(1'b1, 1'b1, 32'h40, 32'hBADBAD00, 1'b1);
        @(negedge clk);
        check("brst_p0_gnt",  32'(bus.p0_gnt),  32'h0);
        check("brst_p1_gnt",  32'(bus.p1_gnt),  32'h0);
        check("brst_mem_wEn", 32'(bus.mem_wEn), 32'h0);
        next_cycle();
        rst = 1'b0;
        set_p1(1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
        @(negedge clk);
        check("post_p0_gnt",    32'(bus.p0_gnt),    32'h1);
        check("post_p1_gnt",    32'(bus.p1_gnt),    32'h0);
        check("post_p1_rvalid", 32'(bus.p1_rvalid), 32'h0);
        check("post_p1_rdata",  bus.p1_rdata,       32'h0);
        next_cycle();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        check("post_p0_rvalid", 32'(bus.p0_rvalid), 32'h1);
        check("post_p0_rdata",  bus.p0_rdata,       32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-port data memory (synchronous write, combinational read) between the pipeline memory-access stage (port 0) and a loader/debug master (port 1). It selects at most one request per cycle, drives the memory control/address/data lines, registers read data back to the winning port, and bounds port-1 starvation. Port 1 can also lock the memory for multi-access bursts. Sits between the memory-access stage and the data memory instance.

## Interface
- MAX_WAIT, 4, consecutive cycles port 1 may be refused before it wins priority (1..15)
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- p0_req / p1_req  in  1  access request, held high with fields stable until granted
- p0_wEn / p1_wEn  in  1  1 = store, 0 = load
- p0_size / p1_size  in  2  access size, passed to memory unchanged
- p0_sign / p1_sign  in  1  load sign-extend select, passed unchanged
- p0_addr / p1_addr  in  32  byte address
- p0_wdata / p1_wdata  in  32  store data
- p1_lock  in  1  port-1 exclusive-ownership request
- p0_gnt / p1_gnt  out  1  combinational grant; req & gnt at an edge = accepted
- p0_rvalid / p1_rvalid  out  1  one-cycle pulse, read data valid
- p0_rdata / p1_rdata  out  32  registered read data, held until that port's next read
- mem_wEn  out  1  memory write enable
- mem_size  out  2  to memory size
- mem_sign  out  1  to memory sign-extend select
- mem_addr  out  32  to memory address
- mem_wdata  out  32  to memory write data
- mem_rdata  in  32  memory combinational read data

## Operation
- States: OPEN, LOCKED. Counter `wait_cnt`, width enough for MAX_WAIT, saturating at MAX_WAIT.
- OPEN grant rule:
  - p0 wins if p0_req and wait_cnt < MAX_WAIT.
  - Otherwise p1 wins if p1_req.
  - If only p1_req, p1 wins.
- LOCKED: only p1 can be granted; p0_gnt = 0.
- Transitions:
  - OPEN -> LOCKED when p1 is granted and p1_lock = 1.
  - LOCKED -> OPEN when p1_lock = 0; evaluated at the edge, and p1 may still complete an access that cycle.
- wait_cnt increments when p1_req & !p1_gnt, clears when p1_gnt or !p1_req, and is held at 0 while LOCKED.
- Memory outputs mux the granted port's fields. With no grant, all mem_* outputs are 0 (mem_wEn = 0 guarantees no write).
- mem_wEn = granted port's wEn. The write occurs at the edge ending the grant cycle.
- Granted load: mem_rdata is captured at the edge into that port's rdata register, and that port's rvalid is 1 for the following cycle. A granted store produces no rvalid.
- Simultaneous grant of one port and rvalid on the other is legal.

## Timing
- Grant is combinational, with zero-cycle request-to-grant latency when uncontended. The critical path is req -> gnt -> mem_addr -> mem_rdata -> capture.
- Load latency: data on pN_rdata and pN_rvalid exactly 1 cycle after the accepting edge.
- Store latency: memory updated at the accepting edge; a load from the same address in the next cycle returns the new data.
- Throughput: one access per cycle total; back-to-back grants to the same port allowed.
- Reset: state OPEN, wait_cnt 0, all gnt/rvalid 0, both rdata registers 0x00000000, mem_* 0 during the rst cycle regardless of requests.
- Reset asserted mid-burst: lock dropped, any pending rvalid suppressed, and no write issued in the rst cycle.
- A requester that drops req before grant is simply not served; no state is retained for it.

## Test plan
- Reset with both req = 1 -> gnt = 0, mem_wEn = 0, rdata = 0 throughout the rst cycle.
- p0 store 0xDEADBEEF to 0x40 size word, then p0 load 0x40 -> p0_rvalid one cycle after load accept, p0_rdata = 0xDEADBEEF, p1_rvalid = 0.
- Both req continuously, MAX_WAIT = 4 -> p0 granted 4 cycles, p1 granted on the 5th, pattern repeats (4:1).
- p1 granted with p1_lock = 1, lock held 3 more cycles while p0_req = 1 -> p0_gnt = 0 for all 4 cycles. On lock release p0 is granted the next cycle.
- Same cycle: p0 load accepted while p1 idle, next cycle p1 store accepted -> p0_rvalid = 1 and mem_wEn = 1 in the same cycle, with correct addresses muxed.
- Burst in progress, rst pulsed one cycle -> state OPEN, wait_cnt 0, no rvalid after reset, p0 granted first when both request.
